// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet transmit scheduler.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [7:0]  ARP_HLEN      = 8'h06;
    localparam logic [7:0]  ARP_PLEN      = 8'h04;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;

    // ARP reply frame length in bytes (no padding, the MAC pads).
    localparam int          ARP_LEN      = 42;
    localparam logic [5:0]  ARP_LAST_IDX = 6'(ARP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARP  = 2'd1,
        UDP  = 2'd2
    } tx_state_t;

    // Which source won the previous grant; used to break ties.
    typedef enum logic {
        GRANT_ARP = 1'b0,
        GRANT_UDP = 1'b1
    } grant_t;

endpackage

// File: rtl/arp_reply_mux.sv
// Combinational selector returning byte `bidx` of the ARP reply frame.
module arp_reply_mux
    import eth_pkg::*;
#(
    parameter logic [47:0] local_mac = 48'h00_0a_35_01_02_03,
    parameter logic [31:0] local_ip  = 32'h10_00_00_80
) (
    input  logic [47:0] act_mac,
    input  logic [31:0] act_ip,
    input  logic [5:0]  bidx,
    output logic [7:0]  byte_o
);

    // Whole reply frame, byte 0 in the most significant position.
    logic [ARP_LEN*8-1:0] frame;

    assign frame = {act_mac, local_mac, ETH_TYPE_ARP,
                    ARP_HTYPE_ETH, ETH_TYPE_IP, ARP_HLEN, ARP_PLEN, ARP_OP_REPLY,
                    local_mac, local_ip, act_mac, act_ip};

    // Pick the addressed byte; indices past the frame end read as zero.
    always_comb begin
        byte_o = 8'h00;
        for (int i = 0; i < ARP_LEN; i++) begin
            if (bidx == 6'(i)) begin
                byte_o = frame[(ARP_LEN-1-i)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Frame-granular scheduler sharing the TX MAC FIFO between generated ARP
// replies and a pass-through UDP frame stream.
//
// Handshake semantics (all streams): a byte transfers on a rising edge where
// valid and ready are both high; once valid is raised, data/last are held
// stable until that transfer happens, and valid never depends on ready.
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter logic [47:0] local_mac = 48'h00_0a_35_01_02_03,
    parameter logic [31:0] local_ip  = 32'h10_00_00_80
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        arp_req,
    input  logic [47:0] arp_remote_mac,
    input  logic [31:0] arp_remote_ip,
    input  logic        udp_tvalid,
    output logic        udp_tready,
    input  logic [7:0]  udp_tdata,
    input  logic        udp_tlast,
    output logic        tx_fifo_tvalid,
    input  logic        tx_fifo_tready,
    output logic [7:0]  tx_fifo_tdata,
    output logic        tx_fifo_tlast,
    output logic        tx_fifo_tuser,
    output logic        busy,
    output logic [15:0] arp_drop_cnt,
    output logic [1:0]  dbg_state
);

    tx_state_t   state_q, state_d;
    logic        pend_q, pend_d;
    logic [47:0] pend_mac_q, pend_mac_d;
    logic [31:0] pend_ip_q, pend_ip_d;
    logic [47:0] act_mac_q, act_mac_d;
    logic [31:0] act_ip_q, act_ip_d;
    logic [5:0]  bidx_q, bidx_d;
    grant_t      last_grant_q, last_grant_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        grant_arp;
    logic        grant_udp;
    logic        arp_fire;
    logic        udp_fire;
    logic [7:0]  arp_byte;

    arp_reply_mux #(
        .local_mac (local_mac),
        .local_ip  (local_ip)
    ) u_arp_reply_mux (
        .act_mac (act_mac_q),
        .act_ip  (act_ip_q),
        .bidx    (bidx_q),
        .byte_o  (arp_byte)
    );

    // Arbitration in IDLE (alternate on ties) and transfer strobes per state.
    always_comb begin
        grant_arp = 1'b0;
        grant_udp = 1'b0;
        if (state_q == IDLE) begin
            if (pend_q && udp_tvalid) begin
                if (last_grant_q == GRANT_UDP) grant_arp = 1'b1;
                else                           grant_udp = 1'b1;
            end else if (pend_q) begin
                grant_arp = 1'b1;
            end else if (udp_tvalid) begin
                grant_udp = 1'b1;
            end
        end
        arp_fire = (state_q == ARP) && tx_fifo_tready;
        udp_fire = (state_q == UDP) && udp_tvalid && tx_fifo_tready;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: a frame, once granted, runs until its last transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_arp)      state_d = ARP;
                else if (grant_udp) state_d = UDP;
            end
            ARP:     if (arp_fire && (bidx_q == ARP_LAST_IDX)) state_d = IDLE;
            UDP:     if (udp_fire && udp_tlast)                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: nothing offered in IDLE, UDP stream is a straight wire.
    always_comb begin
        tx_fifo_tvalid = 1'b0;
        tx_fifo_tdata  = 8'h00;
        tx_fifo_tlast  = 1'b0;
        udp_tready     = 1'b0;
        case (state_q)
            ARP: begin
                tx_fifo_tvalid = 1'b1;
                tx_fifo_tdata  = arp_byte;
                tx_fifo_tlast  = (bidx_q == ARP_LAST_IDX);
            end
            UDP: begin
                tx_fifo_tvalid = udp_tvalid;
                tx_fifo_tdata  = udp_tdata;
                tx_fifo_tlast  = udp_tlast;
                udp_tready     = tx_fifo_tready;
            end
            default: ;
        endcase
    end

    assign tx_fifo_tuser = 1'b0;
    assign busy          = (state_q != IDLE);
    assign arp_drop_cnt  = drop_cnt_q;
    assign dbg_state     = state_q;

    // Pending slot, active reply registers, byte index and drop counter.
    always_comb begin
        pend_d       = pend_q;
        pend_mac_d   = pend_mac_q;
        pend_ip_d    = pend_ip_q;
        act_mac_d    = act_mac_q;
        act_ip_d     = act_ip_q;
        bidx_d       = bidx_q;
        last_grant_d = last_grant_q;
        drop_cnt_d   = drop_cnt_q;

        if (grant_arp) begin
            act_mac_d    = pend_mac_q;
            act_ip_d     = pend_ip_q;
            pend_d       = 1'b0;
            bidx_d       = 6'd0;
            last_grant_d = GRANT_ARP;
        end
        if (grant_udp) begin
            last_grant_d = GRANT_UDP;
        end
        if (arp_fire) begin
            bidx_d = bidx_q + 6'd1;
        end
        // A request arriving while the slot is being granted refills it and
        // is not counted; otherwise an occupied slot is overwritten.
        if (arp_req) begin
            pend_d     = 1'b1;
            pend_mac_d = arp_remote_mac;
            pend_ip_d  = arp_remote_ip;
            if (pend_q && !grant_arp && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q       <= 1'b0;
            pend_mac_q   <= 48'h0;
            pend_ip_q    <= 32'h0;
            act_mac_q    <= 48'h0;
            act_ip_q     <= 32'h0;
            bidx_q       <= 6'd0;
            last_grant_q <= GRANT_UDP;
            drop_cnt_q   <= 16'h0;
        end else begin
            pend_q       <= pend_d;
            pend_mac_q   <= pend_mac_d;
            pend_ip_q    <= pend_ip_d;
            act_mac_q    <= act_mac_d;
            act_ip_q     <= act_ip_d;
            bidx_q       <= bidx_d;
            last_grant_q <= last_grant_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: ARP reply content/latency, arbitration,
// overwrite counting, backpressure and mid-frame reset.
module tb_eth_tx_sched;

    localparam logic [47:0] LMAC = 48'h00_0a_35_01_02_03;
    localparam logic [31:0] LIP  = 32'h10_00_00_80;

    logic        clk;
    logic        resetn;
    logic        arp_req;
    logic [47:0] arp_remote_mac;
    logic [31:0] arp_remote_ip;
    logic        udp_tvalid;
    logic        udp_tready;
    logic [7:0]  udp_tdata;
    logic        udp_tlast;
    logic        tx_fifo_tvalid;
    logic        tx_fifo_tready;
    logic [7:0]  tx_fifo_tdata;
    logic        tx_fifo_tlast;
    logic        tx_fifo_tuser;
    logic        busy;
    logic [15:0] arp_drop_cnt;
    logic [1:0]  dbg_state;

    eth_tx_sched #(
        .local_mac (LMAC),
        .local_ip  (LIP)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .arp_req        (arp_req),
        .arp_remote_mac (arp_remote_mac),
        .arp_remote_ip  (arp_remote_ip),
        .udp_tvalid     (udp_tvalid),
        .udp_tready     (udp_tready),
        .udp_tdata      (udp_tdata),
        .udp_tlast      (udp_tlast),
        .tx_fifo_tvalid (tx_fifo_tvalid),
        .tx_fifo_tready (tx_fifo_tready),
        .tx_fifo_tdata  (tx_fifo_tdata),
        .tx_fifo_tlast  (tx_fifo_tlast),
        .tx_fifo_tuser  (tx_fifo_tuser),
        .busy           (busy),
        .arp_drop_cnt   (arp_drop_cnt),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         got_c[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         hold_viol = 0;
    int         udp_timeout = 0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val = 9'h0;

    // Record each output transfer (sampled mid-cycle for the coming edge)
    // and flag any change of a stalled output.
    always @(negedge clk) begin
        if (resetn && tx_fifo_tvalid && tx_fifo_tready) begin
            got_q.push_back({tx_fifo_tlast, tx_fifo_tdata});
            got_c.push_back(cyc);
        end
        if (resetn && stall_prev) begin
            if (!tx_fifo_tvalid || ({tx_fifo_tlast, tx_fifo_tdata} !== stall_val))
                hold_viol++;
        end
        stall_prev = resetn && tx_fifo_tvalid && !tx_fifo_tready;
        stall_val  = {tx_fifo_tlast, tx_fifo_tdata};
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arp(input logic [47:0] mac, input logic [31:0] ip);
        arp_req        = 1'b1;
        arp_remote_mac = mac;
        arp_remote_ip  = ip;
        tick();
        arp_req        = 1'b0;
    endtask

    task automatic drive_udp(input int len, input logic [7:0] seed);
        bit hs;
        for (int i = 0; i < len; i++) begin
            udp_tvalid = 1'b1;
            udp_tdata  = seed + 8'(i);
            udp_tlast  = (i == len - 1);
            hs = 1'b0;
            for (int k = 0; k < 4000 && !hs; k++) begin
                @(negedge clk);
                hs = udp_tready;
                @(posedge clk);
                #1;
            end
            if (!hs) udp_timeout++;
        end
        udp_tvalid = 1'b0;
        udp_tlast  = 1'b0;
        udp_tdata  = 8'h00;
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_c.delete();
    endtask

    // Expected ARP reply, written field by field.
    task automatic build_arp(input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0] b[$];
        for (int i = 0; i < 6; i++) b.push_back(mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(LMAC[47-8*i -: 8]);
        b.push_back(8'h08); b.push_back(8'h06);
        b.push_back(8'h00); b.push_back(8'h01);
        b.push_back(8'h08); b.push_back(8'h00);
        b.push_back(8'h06); b.push_back(8'h04);
        b.push_back(8'h00); b.push_back(8'h02);
        for (int i = 0; i < 6; i++) b.push_back(LMAC[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) b.push_back(LIP[31-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(mac[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) b.push_back(ip[31-8*i -: 8]);
        for (int i = 0; i < b.size(); i++) exp_q.push_back({(i == b.size() - 1), b[i]});
    endtask

    task automatic build_udp(input int len, input logic [7:0] seed);
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), seed + 8'(i)});
    endtask

    function automatic int seg_errs(input int g0, input int e0, input int n);
        int e = 0;
        for (int k = 0; k < n; k++) begin
            if ((g0 + k >= got_q.size()) || (e0 + k >= exp_q.size())) e++;
            else if (got_q[g0+k] !== exp_q[e0+k]) e++;
        end
        return e;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0; arp_req = 1'b0; arp_remote_mac = 48'h0; arp_remote_ip = 32'h0;
        udp_tvalid = 1'b0; udp_tdata = 8'h0; udp_tlast = 1'b0; tx_fifo_tready = 1'b1;
        #3;
        n_total++; if (tx_fifo_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b exp 0", tx_fifo_tvalid); else n_pass++;
        n_total++; if (tx_fifo_tlast !== 1'b0) $display("FAIL rst_tlast: got %b exp 0", tx_fifo_tlast); else n_pass++;
        n_total++; if (tx_fifo_tdata !== 8'h00) $display("FAIL rst_tdata: got %h exp 00", tx_fifo_tdata); else n_pass++;
        n_total++; if (udp_tready !== 1'b0) $display("FAIL rst_udp_tready: got %b exp 0", udp_tready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (arp_drop_cnt !== 16'h0) $display("FAIL rst_drop_cnt: got %h exp 0000", arp_drop_cnt); else n_pass++;
        n_total++; if (tx_fifo_tuser !== 1'b0) $display("FAIL rst_tuser: got %b exp 0", tx_fifo_tuser); else n_pass++;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();
        n_total++; if (busy !== 1'b0 || tx_fifo_tvalid !== 1'b0) $display("FAIL post_rst_idle: busy %b tvalid %b exp 0 0", busy, tx_fifo_tvalid); else n_pass++;
    endtask

    task automatic test_arp_only();
        int  n;
        int  tl;
        bit  ok;
        clear_sb();
        build_arp(48'h00_11_22_33_44_55, 32'h10_00_00_01);
        n = cyc;
        pulse_arp(48'h00_11_22_33_44_55, 32'h10_00_00_01);
        wait_got(42, 200, ok);
        n_total++; if (!ok) $display("FAIL arp_only_done: got %0d bytes exp 42", got_q.size()); else n_pass++;
        if (ok) begin
            n_total++; if (got_c[0] !== n + 2) $display("FAIL arp_latency: got cycle %0d exp %0d", got_c[0], n + 2); else n_pass++;
            n_total++; if (got_q[0][7:0] !== 8'h00) $display("FAIL arp_byte0: got %h exp 00", got_q[0][7:0]); else n_pass++;
            n_total++; if (got_q[5][7:0] !== 8'h55) $display("FAIL arp_byte5: got %h exp 55", got_q[5][7:0]); else n_pass++;
            n_total++; if ({got_q[20][7:0], got_q[21][7:0]} !== 16'h0002) $display("FAIL arp_opcode: got %h%h exp 0002", got_q[20][7:0], got_q[21][7:0]); else n_pass++;
            n_total++; if ({got_q[38][7:0], got_q[39][7:0], got_q[40][7:0], got_q[41][7:0]} !== 32'h10000001)
                $display("FAIL arp_tpa: got %h%h%h%h exp 10000001", got_q[38][7:0], got_q[39][7:0], got_q[40][7:0], got_q[41][7:0]); else n_pass++;
            tl = 0;
            for (int i = 0; i < 42; i++) if (got_q[i][8]) tl++;
            n_total++; if (tl !== 1 || got_q[41][8] !== 1'b1) $display("FAIL arp_tlast: got %0d tlasts, last flag %b exp 1 1", tl, got_q[41][8]); else n_pass++;
            n_total++; if (got_c[41] - got_c[0] !== 41) $display("FAIL arp_no_gaps: got span %0d exp 41", got_c[41] - got_c[0]); else n_pass++;
        end
        n_total++; if (seg_errs(0, 0, 42) !== 0) $display("FAIL arp_frame: got %0d byte errors exp 0", seg_errs(0, 0, 42)); else n_pass++;
        repeat (10) tick();
        n_total++; if (busy !== 1'b0 || got_q.size() !== 42) $display("FAIL arp_only_idle: busy %b bytes %0d exp 0 42", busy, got_q.size()); else n_pass++;
    endtask

    task automatic test_udp_during_arp();
        bit ok;
        int leak = 0;
        clear_sb();
        build_arp(48'h0a_0b_0c_0d_0e_0f, 32'hc0_a8_01_05);
        build_udp(60, 8'h40);
        pulse_arp(48'h0a_0b_0c_0d_0e_0f, 32'hc0_a8_01_05);
        wait_got(10, 100, ok);
        n_total++; if (!ok) $display("FAIL uda_arp_start: got %0d bytes exp 10", got_q.size()); else n_pass++;
        fork
            drive_udp(60, 8'h40);
            begin
                for (int k = 0; k < 200 && got_q.size() < 42; k++) begin
                    @(negedge clk);
                    if (got_q.size() < 42 && udp_tready) leak++;
                end
            end
        join
        wait_got(102, 200, ok);
        n_total++; if (!ok) $display("FAIL uda_done: got %0d bytes exp 102", got_q.size()); else n_pass++;
        n_total++; if (leak !== 0) $display("FAIL uda_tready_held: got %0d ready cycles during arp exp 0", leak); else n_pass++;
        n_total++; if (seg_errs(0, 0, 42) !== 0) $display("FAIL uda_arp_frame: got %0d errors exp 0", seg_errs(0, 0, 42)); else n_pass++;
        n_total++; if (seg_errs(42, 42, 60) !== 0) $display("FAIL uda_udp_frame: got %0d errors exp 0", seg_errs(42, 42, 60)); else n_pass++;
        if (ok) begin
            n_total++; if (got_c[42] !== got_c[41] + 2) $display("FAIL uda_gap: got cycle %0d exp %0d", got_c[42], got_c[41] + 2); else n_pass++;
        end
        n_total++; if (udp_timeout !== 0) $display("FAIL uda_udp_timeout: got %0d exp 0", udp_timeout); else n_pass++;
    endtask

    task automatic test_tie_alternation();
        bit ok;
        clear_sb();
        build_arp(48'h02_00_00_00_00_03, 32'h0a_00_00_03);
        build_udp(4, 8'h80);
        build_arp(48'h02_00_00_00_00_04, 32'h0a_00_00_04);
        build_udp(4, 8'h90);
        fork
            begin
                pulse_arp(48'h02_00_00_00_00_03, 32'h0a_00_00_03);
                drive_udp(4, 8'h80);
                drive_udp(4, 8'h90);
            end
            begin
                for (int k = 0; k < 100 && got_q.size() < 5; k++) tick();
                pulse_arp(48'h02_00_00_00_00_04, 32'h0a_00_00_04);
            end
        join
        wait_got(92, 300, ok);
        n_total++; if (!ok) $display("FAIL tie_done: got %0d bytes exp 92", got_q.size()); else n_pass++;
        n_total++; if (seg_errs(0, 0, 42) !== 0) $display("FAIL tie_1_arp: got %0d errors exp 0", seg_errs(0, 0, 42)); else n_pass++;
        n_total++; if (seg_errs(42, 42, 4) !== 0) $display("FAIL tie_2_udp: got %0d errors exp 0", seg_errs(42, 42, 4)); else n_pass++;
        n_total++; if (seg_errs(46, 46, 42) !== 0) $display("FAIL tie_3_arp: got %0d errors exp 0", seg_errs(46, 46, 42)); else n_pass++;
        n_total++; if (seg_errs(88, 88, 4) !== 0) $display("FAIL tie_4_udp: got %0d errors exp 0", seg_errs(88, 88, 4)); else n_pass++;
        n_total++; if (arp_drop_cnt !== 16'd0) $display("FAIL tie_no_drop: got %0d exp 0", arp_drop_cnt); else n_pass++;
    endtask

    task automatic test_overwrite();
        bit ok;
        clear_sb();
        build_udp(50, 8'h10);
        build_arp(48'h0c_0c_0c_0c_0c_0c, 32'h0c_00_00_0c);
        fork
            drive_udp(50, 8'h10);
            begin
                for (int k = 0; k < 100 && got_q.size() < 3; k++) tick();
                pulse_arp(48'h0a_0a_0a_0a_0a_0a, 32'h0a_00_00_0a);
                repeat (2) tick();
                pulse_arp(48'h0b_0b_0b_0b_0b_0b, 32'h0b_00_00_0b);
                repeat (2) tick();
                pulse_arp(48'h0c_0c_0c_0c_0c_0c, 32'h0c_00_00_0c);
            end
        join
        wait_got(92, 300, ok);
        n_total++; if (!ok) $display("FAIL ovw_done: got %0d bytes exp 92", got_q.size()); else n_pass++;
        n_total++; if (arp_drop_cnt !== 16'd2) $display("FAIL ovw_drop_cnt: got %0d exp 2", arp_drop_cnt); else n_pass++;
        n_total++; if (seg_errs(0, 0, 50) !== 0) $display("FAIL ovw_udp: got %0d errors exp 0", seg_errs(0, 0, 50)); else n_pass++;
        n_total++; if (seg_errs(50, 50, 42) !== 0) $display("FAIL ovw_arp_third: got %0d errors exp 0", seg_errs(50, 50, 42)); else n_pass++;
        repeat (60) tick();
        n_total++; if (got_q.size() !== 92) $display("FAIL ovw_single_reply: got %0d bytes exp 92", got_q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stop = 1'b0;
        clear_sb();
        hold_viol = 0;
        build_arp(48'h00_de_ad_be_ef_01, 32'hac_10_00_07);
        build_udp(20, 8'hc0);
        fork
            begin
                for (int k = 0; k < 5000 && !stop; k++) begin
                    tick();
                    tx_fifo_tready = ($urandom_range(0, 99) < 30);
                end
            end
            begin
                pulse_arp(48'h00_de_ad_be_ef_01, 32'hac_10_00_07);
                wait_got(1, 100, ok);
                drive_udp(20, 8'hc0);
                wait_got(62, 3000, ok);
                stop = 1'b1;
            end
        join
        tx_fifo_tready = 1'b1;
        n_total++; if (!ok) $display("FAIL bp_done: got %0d bytes exp 62", got_q.size()); else n_pass++;
        n_total++; if (seg_errs(0, 0, 42) !== 0) $display("FAIL bp_arp: got %0d errors exp 0", seg_errs(0, 0, 42)); else n_pass++;
        n_total++; if (seg_errs(42, 42, 20) !== 0) $display("FAIL bp_udp: got %0d errors exp 0", seg_errs(42, 42, 20)); else n_pass++;
        n_total++; if (hold_viol !== 0) $display("FAIL bp_hold: got %0d unstable stalls exp 0", hold_viol); else n_pass++;
        repeat (5) tick();
        n_total++; if (got_q.size() !== 62) $display("FAIL bp_count: got %0d bytes exp 62", got_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_arp();
        bit ok;
        int n;
        clear_sb();
        pulse_arp(48'h06_06_06_06_06_06, 32'h06_00_00_06);
        wait_got(5, 100, ok);
        pulse_arp(48'h07_07_07_07_07_07, 32'h07_00_00_07);
        wait_got(20, 100, ok);
        n_total++; if (!ok) $display("FAIL rma_reach_byte20: got %0d bytes exp 20", got_q.size()); else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        n_total++; if (tx_fifo_tvalid !== 1'b0) $display("FAIL rma_async_tvalid: got %b exp 0", tx_fifo_tvalid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rma_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (arp_drop_cnt !== 16'd0) $display("FAIL rma_drop_cnt: got %0d exp 0", arp_drop_cnt); else n_pass++;
        repeat (2) tick();
        resetn = 1'b1;
        clear_sb();
        repeat (60) tick();
        n_total++; if (got_q.size() !== 0) $display("FAIL rma_pend_cleared: got %0d bytes exp 0", got_q.size()); else n_pass++;
        build_arp(48'h08_08_08_08_08_08, 32'h08_00_00_08);
        n = cyc;
        pulse_arp(48'h08_08_08_08_08_08, 32'h08_00_00_08);
        wait_got(42, 200, ok);
        n_total++; if (!ok) $display("FAIL rma_new_done: got %0d bytes exp 42", got_q.size()); else n_pass++;
        if (ok) begin
            n_total++; if (got_c[0] !== n + 2) $display("FAIL rma_new_latency: got cycle %0d exp %0d", got_c[0], n + 2); else n_pass++;
        end
        n_total++; if (seg_errs(0, 0, 42) !== 0) $display("FAIL rma_new_frame: got %0d errors exp 0", seg_errs(0, 0, 42)); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_arp_only();
        test_udp_during_arp();
        test_tie_alternation();
        test_overwrite();
        test_backpressure();
        test_reset_mid_arp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
